// File: rtl/ray_dir_generator_pkg.sv
// ray_dir_generator_pkg: shared widths, lane offsets and FSM encoding for the ray direction generator
package ray_dir_generator_pkg;
  localparam int VEC_W = 96;
  localparam int LANE_W = 32;
  localparam int FRAC_BITS = 16;
  localparam int LANE_X = 0;
  localparam int LANE_Y = 32;
  localparam int LANE_Z = 64;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_e;
endpackage

// File: rtl/ray_dir_generator_addsub.sv
// vec3_addsub: three independent 32-bit lanes, each adding or subtracting b from a (modulo 2^32)
module vec3_addsub
  import ray_dir_generator_pkg::*;
(
  input  logic [VEC_W-1:0] a_i,
  input  logic [VEC_W-1:0] b_i,
  input  logic [2:0]       sub_i,
  output logic [VEC_W-1:0] y_o
);
  for (genvar i = 0; i < 3; i++) begin : g_lane
    assign y_o[i*LANE_W +: LANE_W] = sub_i[i] ? a_i[i*LANE_W +: LANE_W] - b_i[i*LANE_W +: LANE_W]
                                              : a_i[i*LANE_W +: LANE_W] + b_i[i*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/ray_dir_generator.sv
// ray_dir_generator: walks the frame in raster order with adders only, issuing one camera-ray direction per pixel
module ray_dir_generator
  import ray_dir_generator_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] cam_forward,
  input  logic [VEC_W-1:0] cam_right,
  input  logic [VEC_W-1:0] cam_up,
  input  logic             hold,
  output logic [VEC_W-1:0] v,
  output logic             new_data,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic             busy,
  output logic             frame_done
);
  localparam int K = H_RES > V_RES ? H_RES / 2 : V_RES / 2;
  state_e state_q, state_d;
  logic [VEC_W-1:0] right_q, up_q, cur_q, row_q, v_q;
  logic [VEC_W-1:0] a_a, a_b, a_y, b_b, sum;
  logic [2:0]       a_sub;
  logic [CW-1:0]    cnt_q;
  logic [XW-1:0]    x_q, px_q;
  logic [YW-1:0]    y_q, py_q;
  logic             nd_q, fd_q, busy_q;
  logic             scan, issue, eol, last;
  assign scan  = state_q == SCAN;
  assign issue = scan && !hold;
  assign eol   = x_q == XW'(H_RES - 1);
  assign last  = eol && y_q == YW'(V_RES - 1);
  // SETUP: cur - right + up; SCAN: cur + right, or row_base - up at end of row
  assign a_a   = scan && eol ? row_q : cur_q;
  assign a_b   = scan ? (eol ? up_q : right_q) : (cnt_q < CW'(H_RES / 2) ? right_q : '0);
  assign a_sub = scan && !eol ? 3'b000 : 3'b111;
  assign b_b   = state_q == SETUP && cnt_q < CW'(V_RES / 2) ? up_q : '0;
  vec3_addsub u_step (.a_i(a_a), .b_i(a_b), .sub_i(a_sub), .y_o(a_y));
  vec3_addsub u_up (.a_i(a_y), .b_i(b_b), .sub_i(3'b000), .y_o(sum));
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (start ? SETUP : IDLE) :
              state_q == SETUP ? (cnt_q == CW'(K) ? SCAN : SETUP) :
              state_q == SCAN  ? (issue && last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      right_q <= '0;
      up_q    <= '0;
      cur_q   <= '0;
      row_q   <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      nd_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nd_q    <= issue;
      fd_q    <= state_q == DONE;
      // busy covers the frame_done cycle, so it drops one cycle after DONE
      busy_q  <= state_d != IDLE || state_q == DONE;
      case (state_q)
        IDLE: if (start) begin
          right_q <= cam_right;
          up_q    <= cam_up;
          cur_q   <= cam_forward;
          cnt_q   <= '0;
        end
        SETUP: if (cnt_q == CW'(K)) begin
          row_q <= cur_q;
          x_q   <= '0;
          y_q   <= '0;
        end else begin
          cur_q <= sum;
          cnt_q <= cnt_q + 1'b1;
        end
        SCAN: if (issue) begin
          v_q   <= cur_q;
          px_q  <= x_q;
          py_q  <= y_q;
          cur_q <= sum;
          if (eol) begin
            row_q <= sum;
            x_q   <= '0;
            y_q   <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign v          = v_q;
  assign new_data   = nd_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_ray_dir_generator.sv
// tb_ray_dir_generator: scoreboard bench for a 4x2 frame, covering hold, ignored start, reset abort, wrap and back-to-back frames
module tb_ray_dir_generator;
  localparam int H = 4;
  localparam int V = 2;
  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [95:0] cam_forward, cam_right, cam_up, v;
  logic        new_data, busy, frame_done;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;
  logic [98:0] sb[$];
  int          n_chk = 0, n_fail = 0, n_strobe = 0, n_fd = 0;
  logic        prev_nd = 1'b0;
  localparam logic [95:0] FWD  = {32'h00010000, 32'h0, 32'h0};
  localparam logic [95:0] RT   = {32'h0, 32'h0, 32'h00004000};
  localparam logic [95:0] UP   = {32'h0, 32'h00004000, 32'h0};
  localparam logic [95:0] WFWD = {32'h00010000, 32'h0, 32'h7FFF0000};
  localparam logic [95:0] WRT  = {32'h0, 32'h0, 32'h00010000};
  ray_dir_generator #(.H_RES(H), .V_RES(V), .XW(2), .YW(1), .CW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cam_forward(cam_forward), .cam_right(cam_right),
    .cam_up(cam_up), .hold(hold), .v(v), .new_data(new_data), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [95:0] exp_v(logic [95:0] f, logic [95:0] r, logic [95:0] u, int x, int y);
    logic [95:0] e;
    for (int i = 0; i < 3; i++)
      e[i*32 +: 32] = f[i*32 +: 32] - 32'(H / 2) * r[i*32 +: 32] + 32'(V / 2) * u[i*32 +: 32]
                    + 32'(x) * r[i*32 +: 32] - 32'(y) * u[i*32 +: 32];
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(logic [95:0] f, logic [95:0] r, logic [95:0] u);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        sb.push_back({1'(y), 2'(x), exp_v(f, r, u, x, y)});
    cam_forward = f;
    cam_right = r;
    cam_up = u;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_pix(int x, int y);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (new_data === 1'b1 && pix_x == 2'(x) && pix_y == 1'(y)) return;
    end
    check("wait_pix_timeout", 0, 1);
  endtask
  task automatic wait_fd(string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      tick();
      if (frame_done === 1'b1) break;
    end
    check({tag, "_fd_seen"}, frame_done, 1);
    check({tag, "_busy_in_fd"}, busy, 1);
    tick();
    check({tag, "_fd_fall"}, frame_done, 0);
    check({tag, "_busy_fall"}, busy, 0);
  endtask
  always @(negedge clk) begin
    if (new_data === 1'b1) begin
      n_strobe++;
      if (sb.size() == 0) check("unexpected_strobe", 1, 0);
      else check("pixel", {pix_y, pix_x, v}, sb.pop_front());
    end
    if (frame_done === 1'b1) begin
      n_fd++;
      check("fd_after_last_strobe", prev_nd, 1);
      check("fd_sb_drained", sb.size(), 0);
    end
    prev_nd = new_data;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, f0;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    cam_forward = '0; cam_right = '0; cam_up = '0;
    repeat (3) tick();
    check("rst_v", v, 0);
    check("rst_nd", new_data, 0);
    check("rst_pix", {pix_y, pix_x}, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_beats_start", busy, 0);
    rst = 1'b0;
    tick();
    s0 = n_strobe;
    kick(FWD, RT, UP);
    check("busy_after_start", busy, 1);
    repeat (3) tick();
    check("no_strobe_edge3", new_data, 0);
    tick();
    check("first_strobe_edge4", new_data, 1);
    check("pix00", {pix_y, pix_x, v}, {1'b0, 2'd0, 32'h00010000, 32'h00004000, 32'hFFFF8000});
    for (int i = 1; i < H * V; i++) begin
      tick();
      check("consecutive", new_data, 1);
      if (i == 3) check("pix30_x", v[31:0], 32'h00004000);
      if (i == 4) check("pix01_y", v[63:32], 32'h0);
    end
    tick();
    check("basic_fd", frame_done, 1);
    check("basic_busy_fd", busy, 1);
    tick();
    check("basic_busy_fall", busy, 0);
    check("basic_count", n_strobe - s0, H * V);
    s0 = n_strobe;
    kick(FWD, RT, UP);
    wait_pix(1, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_no_strobe", new_data, 0);
      check("hold_keep_x", pix_x, 1);
    end
    hold = 1'b0;
    tick();
    check("hold_release_pix", {new_data, pix_x, v[31:0]}, {1'b1, 2'd2, 32'h0});
    wait_fd("hold");
    check("hold_count", n_strobe - s0, H * V);
    kick(FWD, RT, UP);
    wait_pix(1, 0);
    cam_forward = WFWD;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fd("busy_start");
    kick(FWD, RT, UP);
    wait_pix(1, 1);
    rst = 1'b1;
    tick();
    check("midrst_v", v, 0);
    check("midrst_nd", new_data, 0);
    check("midrst_pix", {pix_y, pix_x}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fd", frame_done, 0);
    sb.delete();
    rst = 1'b0;
    f0 = n_fd;
    repeat (10) tick();
    check("midrst_no_fd", n_fd, f0);
    kick(FWD, RT, UP);
    wait_fd("after_rst");
    kick(WFWD, WRT, UP);
    wait_pix(3, 0);
    check("wrap_x", v[31:0], 32'h80000000);
    wait_fd("wrap");
    s0 = n_strobe;
    kick(FWD, RT, UP);
    wait_fd("b2b_1");
    kick(FWD, RT, UP);
    wait_fd("b2b_2");
    check("b2b_count", n_strobe - s0, 2 * H * V);
    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ray_dir_generator.md
Name: ray_dir_generator

Overview:
- Upstream feeder of the vector normalizer pipeline; produces one un-normalized camera-ray direction per screen pixel, in raster order.
- On start, latches camera basis vectors and walks the frame with adders only. Each direction is issued as a 96-bit {z,y,x} 32-bit signed fixed-point vector with a new_data strobe, tagged with pixel coordinates.
- The downstream normalizer has no backpressure. Flow control is therefore a hold input, driven by the consumer FIFO's almost-full flag.

Parameters:
- H_RES, 640, pixels per row; even, >=2
- V_RES, 480, rows per frame; even, >=2
- XW, 10, pix_x width; 2^XW >= H_RES
- YW, 9, pix_y width; 2^YW >= V_RES
- CW, 10, setup counter width; 2^CW > max(H_RES/2, V_RES/2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- cam_forward  in  96  {z,y,x} view-centre direction, latched on accepted start
- cam_right  in  96  per-pixel step to the right, latched on accepted start
- cam_up  in  96  per-row step upward, latched on accepted start
- hold  in  1  downstream stall; 1 = issue nothing this cycle
- v  out  96  ray direction {z,y,x}, registered
- new_data  out  1  v/pix_x/pix_y valid this cycle (single-cycle strobe)
- pix_x  out  XW  column of v
- pix_y  out  YW  row of v
- busy  out  1  1 outside IDLE
- frame_done  out  1  one-cycle pulse after last pixel issued

Behaviour:
- Reset (synchronous, active-high): state=IDLE. v=0, new_data=0, pix_x=0, pix_y=0, busy=0, frame_done=0. All internal accumulators and counters cleared.
- Reset mid-frame: aborts at the next edge. No further new_data, no frame_done.
- Arithmetic: per-lane 32-bit two's complement add/sub, modulo 2^32. No saturation; wrap-around is the defined result.
- IDLE:
  - start=1 latches the three vectors, sets acc=cam_forward, cnt=0, and goes to SETUP.
  - start=0 stays in IDLE.
  - start is ignored in every other state.
- SETUP, one cycle per step, hold ignored:
  - acc <= acc - (cnt<H_RES/2 ? right : 0) + (cnt<V_RES/2 ? up : 0); cnt++.
  - After K=max(H_RES/2,V_RES/2) steps, acc = top-left direction. Then row_base=acc, cur=acc, x=0, y=0, and go to SCAN.
- SCAN, hold=1: nothing advances, new_data=0 next cycle, and v/pix_x/pix_y keep their last values.
- SCAN, hold=0: next edge drives v=cur, pix_x=x, pix_y=y, new_data=1.
  - Not end of row: cur += right, x++.
  - End of row (x=H_RES-1): x=0, y++, row_base -= up, cur = row_base - up.
  - Last pixel (x=H_RES-1, y=V_RES-1): go to DONE.
- DONE: frame_done=1 for one cycle, busy stays 1 that cycle, then IDLE. start is accepted again from the following cycle.
- Latency:
  - start sampled at edge 0; first new_data registered at edge K+2.
  - With hold=0 throughout, one strobe per cycle and exactly H_RES*V_RES strobes per frame.
  - frame_done is asserted the cycle after the last strobe.
- hold is sampled combinationally in SCAN, so it stalls the same-edge issue. The consumer must assert it with at least 52 entries of FIFO headroom (normalizer latency 50, plus 2).
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared package constants:
  - VEC_W=96, LANE_W=32, FRAC_BITS=16 (Q16.16).
  - Lane slice offsets X=0, Y=32, Z=64.
  - State encoding IDLE/SETUP/SCAN/DONE.
- One sub-module, vec3_addsub: combinational 3-lane add/sub with a per-lane op select, reused for the SETUP and SCAN updates.

Test Plan (H_RES=4, V_RES=2, so K=2; cam_forward x=0, y=0, z=0x00010000; cam_right x=0x00004000; cam_up y=0x00004000; other lanes 0):
- Basic frame, hold=0: start at cycle 0.
  - Pixel (0,0) v={z=0x00010000, y=0x00004000, x=0xFFFF8000}, new_data first at edge 4.
  - Pixel (3,0) x=0x00004000; pixel (0,1) y=0x00000000.
  - 8 strobes on consecutive cycles; frame_done the cycle after pixel (3,1); busy falls the cycle after that.
- Hold: assert hold for 3 cycles after pixel (1,0).
  - No strobes during hold; pixel (2,0) x=0x00000000 follows the release with no skipped or duplicated pixel.
  - Still 8 strobes total.
- Start while busy: pulse start with a different cam_forward mid-SCAN.
  - Ignored; outputs match the basic frame exactly.
- Reset mid-frame: rst during pixel (2,1).
  - All outputs 0 at the next edge, no frame_done.
  - A subsequent start reproduces the basic frame.
- Wrap-around: cam_forward x=0x7FFF0000, cam_right x=0x00010000.
  - Pixel (3,0) x = 0x7FFF0000 - 0x20000 + 0x30000 = 0x80000000 (wraps negative, no saturation).
- Back-to-back frames: start asserted the cycle frame_done falls.
  - Accepted; second frame identical; exactly 16 strobes total.
